// File: rtl/scc_pkg.sv
// Shared constants and types for the SCC/SCC+ wavetable sound core.
package scc_pkg;

  // Address map anchors inside the mapper's sound window
  localparam logic [7:0] SCC_REG_BASE    = 8'h80;
  localparam logic [7:0] SCCP_REG_BASE   = 8'hA0;
  localparam logic [7:0] SCC_SHARED_BASE = 8'h60;
  localparam logic [7:0] SCC_CH4_RD_BASE = 8'hA0;

  // Datapath widths
  localparam int SAMPLE_W = 8;
  localparam int VOL_W    = 4;
  localparam int IDX_W    = 5;
  localparam int ACC_W    = 15;
  localparam int PROD_W   = 13;

  // Periods below this freeze the voice
  localparam int MIN_PERIOD = 9;

  typedef enum logic [1:0] {
    MIX_IDLE = 2'd0,
    MIX_ACC  = 2'd1,
    MIX_OUT  = 2'd2
  } mix_state_t;

endpackage

// File: rtl/scc_voice.sv
// One wavetable voice: period register, down-counter and sample index.
module scc_voice
  import scc_pkg::*;
#(
  parameter int PERIOD_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             per_wr_lo,
  input  logic             per_wr_hi,
  input  logic [7:0]       din,
  output logic [IDX_W-1:0] index
);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic [PERIOD_W-1:0] new_period;

  // Merge a CPU byte / nibble write into the current period
  always_comb begin
    new_period = period;
    if (per_wr_lo) new_period[7:0] = din;
    if (per_wr_hi) new_period[PERIOD_W-1:8] = din[PERIOD_W-9:0];
  end

  // Period write reloads the counter; otherwise step the voice on ce
  always_ff @(posedge clk) begin
    if (reset) begin
      period  <= '0;
      counter <= '0;
      index   <= '0;
    end else if (per_wr_lo || per_wr_hi) begin
      period  <= new_period;
      counter <= new_period;
    end else if (ce && (period >= PERIOD_W'(MIN_PERIOD))) begin
      if (counter == '0) begin
        counter <= period;
        index   <= index + 1'b1;
      end else begin
        counter <= counter - 1'b1;
      end
    end
  end

endmodule

// File: rtl/scc_wave_core.sv
// SCC/SCC+ wavetable sound core: register map, wave RAM, voices and mixer.
// Bus handshake: wr/rd are single-clk strobes with no back-pressure; read
// data appears on dout the clk after rd and is held until the next rd.
module scc_wave_core
  import scc_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter int PERIOD_W = 12,
  parameter int OUT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    scc_plus,
  input  logic [7:0]              addr,
  input  logic [7:0]              din,
  input  logic                    wr,
  input  logic                    rd,
  output logic [7:0]              dout,
  output logic signed [OUT_W-1:0] sound,
  output logic                    sound_valid
);

  localparam int WAVE_LEN = 2 ** IDX_W;

  logic [SAMPLE_W-1:0] wave     [CHANNELS][WAVE_LEN];
  logic [VOL_W-1:0]    volume   [CHANNELS];
  logic [CHANNELS-1:0] enable;
  logic [IDX_W-1:0]    index    [CHANNELS];
  logic [IDX_W-1:0]    snap_idx [CHANNELS];

  logic                wave_hit, shared_hit, reg_hit, rd_hit;
  logic [2:0]          wave_ch, rd_ch;
  logic [CHANNELS-1:0] wave_we, per_lo_we, per_hi_we, vol_we;
  logic                en_we;
  logic [7:0]          rdata;

  // Address decode; the map depends on scc_plus at the time of access
  always_comb begin
    wave_hit   = 1'b0;
    shared_hit = 1'b0;
    reg_hit    = 1'b0;
    rd_hit     = 1'b0;
    wave_ch    = addr[7:5];
    rd_ch      = addr[7:5];
    if (scc_plus) begin
      wave_hit = (addr < SCCP_REG_BASE);
      reg_hit  = (addr[7:4] == SCCP_REG_BASE[7:4]);
      rd_hit   = wave_hit;
    end else begin
      wave_hit   = (addr < SCC_REG_BASE);
      shared_hit = wave_hit && (addr >= SCC_SHARED_BASE);
      reg_hit    = (addr[7:5] == SCC_REG_BASE[7:5]);
      rd_hit     = wave_hit || (addr[7:5] == SCC_CH4_RD_BASE[7:5]);
      if (!wave_hit) rd_ch = 3'd4;
    end
  end

  // Per-channel write strobes; channels beyond CHANNELS simply never match
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      wave_we[c]   = wr && wave_hit && ((wave_ch == 3'(c)) || (shared_hit && (c == 4)));
      per_lo_we[c] = wr && reg_hit && (addr[3:0] == 4'(2 * c));
      per_hi_we[c] = wr && reg_hit && (addr[3:0] == 4'(2 * c + 1));
      vol_we[c]    = wr && reg_hit && (addr[3:0] == 4'(10 + c));
    end
    en_we = wr && reg_hit && (addr[3:0] == 4'hF);
  end

  // Read mux: wave RAM bytes, everything else reads as 0xFF
  always_comb begin
    rdata = 8'hFF;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_hit && (rd_ch == 3'(c))) rdata = wave[c][addr[IDX_W-1:0]];
    end
  end

  // Wave RAM, volume and enable registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        volume[c] <= '0;
        for (int i = 0; i < WAVE_LEN; i++) wave[c][i] <= '0;
      end
      enable <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wave_we[c]) wave[c][addr[IDX_W-1:0]] <= din;
        if (vol_we[c])  volume[c] <= din[VOL_W-1:0];
      end
      if (en_we) enable <= din[CHANNELS-1:0];
    end
  end

  // Read data register; a simultaneous write forces 0xFF
  always_ff @(posedge clk) begin
    if (reset)   dout <= 8'hFF;
    else if (rd) dout <= wr ? 8'hFF : rdata;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_voice
    scc_voice #(.PERIOD_W(PERIOD_W)) u_voice (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .per_wr_lo (per_lo_we[c]),
      .per_wr_hi (per_hi_we[c]),
      .din       (din),
      .index     (index[c])
    );
  end

  mix_state_t                 state, state_nxt;
  logic [2:0]                 ch_cnt;
  logic signed [ACC_W-1:0]    acc;
  logic                       start_mix, acc_en, load_out;
  logic [SAMPLE_W-1:0]        mix_sample;
  logic [VOL_W-1:0]           mix_vol;
  logic                       mix_en;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    term;

  // Mixer state register
  always_ff @(posedge clk) begin
    if (reset) state <= MIX_IDLE;
    else       state <= state_nxt;
  end

  // Mixer next state; ce outside IDLE does not restart the mix
  always_comb begin
    state_nxt = state;
    case (state)
      MIX_IDLE: if (ce) state_nxt = MIX_ACC;
      MIX_ACC:  if (ch_cnt == 3'(CHANNELS - 1)) state_nxt = MIX_OUT;
      MIX_OUT:  state_nxt = MIX_IDLE;
      default:  state_nxt = MIX_IDLE;
    endcase
  end

  // Mixer control outputs
  always_comb begin
    start_mix = (state == MIX_IDLE) && ce;
    acc_en    = (state == MIX_ACC);
    load_out  = (state == MIX_OUT);
  end

  // Current channel's contribution: live wave/volume/enable, snapshotted index
  always_comb begin
    mix_sample = '0;
    mix_vol    = '0;
    mix_en     = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_cnt == 3'(c)) begin
        mix_sample = wave[c][snap_idx[c]];
        mix_vol    = volume[c];
        mix_en     = enable[c];
      end
    end
    prod = $signed(mix_sample) * $signed({1'b0, mix_vol});
    term = mix_en ? {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod} : '0;
  end

  // Mixer datapath: index snapshot, accumulation and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      ch_cnt      <= '0;
      sound       <= '0;
      sound_valid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) snap_idx[c] <= '0;
    end else begin
      sound_valid <= 1'b0;
      if (start_mix) begin
        acc    <= '0;
        ch_cnt <= '0;
        for (int c = 0; c < CHANNELS; c++) snap_idx[c] <= index[c];
      end else if (acc_en) begin
        acc    <= acc + term;
        ch_cnt <= ch_cnt + 3'd1;
      end
      if (load_out) begin
        sound       <= {{(OUT_W - ACC_W){acc[ACC_W-1]}}, acc};
        sound_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scc_wave_core.sv
// Directed self-checking bench for scc_wave_core.
module tb_scc_wave_core;

  localparam int CHANNELS = 5;
  localparam int PERIOD_W = 12;
  localparam int OUT_W    = 16;

  logic                    clk = 1'b0;
  logic                    reset, ce, scc_plus, wr, rd;
  logic [7:0]              addr, din, dout;
  logic signed [OUT_W-1:0] sound;
  logic                    sound_valid;

  int n_cmp = 0;
  int n_bad = 0;

  scc_wave_core #(.CHANNELS(CHANNELS), .PERIOD_W(PERIOD_W), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .scc_plus    (scc_plus),
    .addr        (addr),
    .din         (din),
    .wr          (wr),
    .rd          (rd),
    .dout        (dout),
    .sound       (sound),
    .sound_valid (sound_valid)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic bus_write(input logic plus, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    scc_plus = plus; addr = a; din = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic plus, input logic [7:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    scc_plus = plus; addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    d = dout;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Pulse ce and count sound_valid pulses over the following 8 clk
  task automatic ce_pulse(output int nvalid);
    nvalid = 0;
    @(posedge clk); #1 ce = 1'b1;
    @(posedge clk); #1 ce = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (sound_valid) nvalid++;
    end
  endtask

  // Pulse ce and wait (bounded) for the resulting sample
  task automatic ce_sample(output logic signed [31:0] s, output int lat);
    @(posedge clk); #1 ce = 1'b1;
    @(posedge clk); #1 ce = 1'b0;
    lat = -1;
    s   = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sound_valid) begin
        lat = i;
        s   = sound;
        break;
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]         d;
    logic signed [31:0] s;
    int                 lat, nv, vcount, nz;

    reset = 1'b1; ce = 1'b0; scc_plus = 1'b0; wr = 1'b0; rd = 1'b0;
    addr = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, ce pulses while held in reset
    vcount = 0;
    repeat (10) begin
      ce_pulse(nv);
      vcount += nv;
    end
    check("valid_during_reset", vcount, 0);
    @(posedge clk); #1 reset = 1'b0;
    check("reset_dout", dout, 8'hFF);
    check("reset_sound", sound, 0);
    check("reset_valid", sound_valid, 0);
    bus_read(1'b0, 8'h00, d);
    check("rd_wave_after_reset", d, 8'h00);
    bus_read(1'b0, 8'h8F, d);
    check("rd_reg_ff", d, 8'hFF);

    // SCC: single voice, period 0x010
    bus_write(1'b0, 8'h00, 8'h7F);
    bus_write(1'b0, 8'h01, 8'h10);
    bus_write(1'b0, 8'h80, 8'h10);
    bus_write(1'b0, 8'h81, 8'h00);
    bus_write(1'b0, 8'h8A, 8'h0F);
    bus_write(1'b0, 8'h8F, 8'h01);
    for (int k = 1; k <= 18; k++) begin
      ce_sample(s, lat);
      if (k == 1) begin
        check("latency", lat, 6);
        check("sound_ch0", s, 1905);
        check("valid_one_clk", sound_valid, 0);
      end
      if (k == 16) check("idx0_sample16", s, 1905);
      if (k == 18) check("idx1_sample18", s, 240);
    end

    // SCC: shared ch3/ch4 waveform
    bus_write(1'b0, 8'h60, 8'h80);
    bus_read(1'b0, 8'hA0, d);
    check("scc_ch4_rd", d, 8'h80);
    bus_read(1'b0, 8'h60, d);
    check("scc_ch3_rd", d, 8'h80);
    bus_write(1'b0, 8'h8D, 8'h0F);
    bus_write(1'b0, 8'h8E, 8'h0F);
    bus_write(1'b0, 8'h8F, 8'h18);
    ce_sample(s, lat);
    check("sound_ch3_ch4", s, -3840);

    // SCC+: independent waveforms, moved register block
    do_reset();
    bus_write(1'b1, 8'h80, 8'h11);
    bus_read(1'b1, 8'h60, d);
    check("sccp_ch3_not_shared", d, 8'h00);
    bus_read(1'b1, 8'h80, d);
    check("sccp_ch4_rd", d, 8'h11);
    bus_read(1'b1, 8'hA0, d);
    check("sccp_reg_rd_ff", d, 8'hFF);
    bus_write(1'b1, 8'hAE, 8'h0F);
    bus_write(1'b1, 8'hAF, 8'h10);
    ce_sample(s, lat);
    check("sccp_sound_ch4", s, 255);
    bus_write(1'b0, 8'hA0, 8'h55);
    bus_read(1'b0, 8'hA0, d);
    check("scc_a0_write_ignored", d, 8'h11);
    bus_write(1'b0, 8'h9E, 8'h01);
    ce_sample(s, lat);
    check("scc_mirror_volume", s, 17);
    @(posedge clk); #1;
    scc_plus = 1'b1; addr = 8'h01; din = 8'h22; wr = 1'b1; rd = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    check("wr_rd_dout_ff", dout, 8'hFF);
    bus_read(1'b1, 8'h01, d);
    check("wr_rd_write_done", d, 8'h22);

    // Freeze below minimum period, then period 9 with wrap
    do_reset();
    for (int i = 0; i < 32; i++) bus_write(1'b0, 8'(i), 8'(i + 1));
    bus_write(1'b0, 8'h8A, 8'h01);
    bus_write(1'b0, 8'h8F, 8'h01);
    bus_write(1'b0, 8'h80, 8'h08);
    repeat (100) ce_pulse(nv);
    ce_sample(s, lat);
    check("frozen_period8", s, 1);
    bus_write(1'b0, 8'h80, 8'h09);
    for (int k = 1; k <= 325; k++) begin
      ce_sample(s, lat);
      if (k == 5)   check("p9_idx0", s, 1);
      if (k == 15)  check("p9_idx1", s, 2);
      if (k == 315) check("p9_idx31", s, 32);
      if (k == 325) check("p9_wrap0", s, 1);
    end

    // Reset in the middle of accumulation
    bus_write(1'b0, 8'h8A, 8'h0F);
    @(posedge clk); #1 ce = 1'b1;
    @(posedge clk); #1 ce = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    vcount = 0;
    nz = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (sound_valid) vcount++;
      if (sound !== '0) nz++;
    end
    check("midacc_no_valid", vcount, 0);
    check("midacc_sound_zero", nz, 0);
    ce_sample(s, lat);
    check("post_reset_latency", lat, 6);
    check("post_reset_sample", s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
